// File: rtl/fp_accum_seq_pkg.sv
// fp_accum_seq shared types: FSM states, float32 constants and field widths.
// Optional watchdog build macro: FPACC_TIMEOUT_EN.
package fpacc_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_OUT
  } state_t;

  localparam int SIGN_W = 1;
  localparam int EXP_W  = 8;
  localparam int MAN_W  = 23;
  localparam int FP_W   = SIGN_W + EXP_W + MAN_W;

  localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC00000;
  localparam logic [FP_W-1:0] FP_ZERO = 32'h00000000;

endpackage

// File: rtl/fp_accum_seq_if.sv
// Operand stream in, packet sum out, and the side-channel to the fpadd unit.
// slave is the accumulator's view; master is the surrounding system's view.
interface fp_accum_seq_if
  import fpacc_pkg::*;
#(
    parameter int CNT_W = 16
);
  logic            in_valid;
  logic            in_ready;
  logic [FP_W-1:0] in_data;
  logic            in_last;

  logic             out_valid;
  logic             out_ready;
  logic [FP_W-1:0]  out_data;
  logic [CNT_W-1:0] out_count;
  logic             out_err;

  logic            add_start;
  logic [FP_W-1:0] add_a;
  logic [FP_W-1:0] add_b;
  logic [FP_W-1:0] add_sum;
  logic            add_done;

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready,
    output out_valid, out_data, out_count, out_err,
    input  out_ready,
    output add_start, add_a, add_b,
    input  add_sum, add_done
  );

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready,
    input  out_valid, out_data, out_count, out_err,
    output out_ready,
    input  add_start, add_a, add_b,
    output add_sum, add_done
  );
endinterface

// File: rtl/fp_accum_seq.sv
// Packet accumulator sequencing an external multi-cycle fpadd unit.
// Define FPACC_TIMEOUT_EN to add a watchdog on the adder's done signal.
module fp_accum_seq
  import fpacc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 300,
    parameter int CNT_W          = 16
) (
    input logic clk,
    input logic reset,
    fp_accum_seq_if.slave io
);

  state_t state, state_n;

  logic             first;
  logic [FP_W-1:0]  acc;
  logic [FP_W-1:0]  b_reg;
  logic             last_reg;
  logic [CNT_W-1:0] cnt;
  logic             armed;

  logic             xfer;
  logic             take;
  logic [FP_W-1:0]  res;
  logic             in_ready;
  logic             out_valid;
  logic             add_start;

  assign xfer = io.in_valid & in_ready;

`ifdef FPACC_TIMEOUT_EN
  logic [31:0] wd;
  logic        err;
  logic        tmo;

  assign tmo = (wd == 32'(TIMEOUT_CYCLES)) & ~io.add_done;
  assign take = (state == S_WAIT) & armed & (io.add_done | tmo);
  assign res = tmo ? FP_QNAN : io.add_sum;

  always_ff @(posedge clk) begin
    if (reset) begin
      wd  <= '0;
      err <= 1'b0;
    end else begin
      if (state == S_WAIT) wd <= wd + 32'd1;
      else                 wd <= '0;
      if (state == S_WAIT && armed && tmo) err <= 1'b1;
    end
  end

  assign io.out_err = err;
`else
  assign take = (state == S_WAIT) & armed & io.add_done;
  assign res = io.add_sum;
  assign io.out_err = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    add_start = 1'b0;
    unique case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (xfer) begin
          if (first) state_n = io.in_last ? S_OUT : S_IDLE;
          else       state_n = S_ISSUE;
        end
      end
      S_ISSUE: begin
        add_start = 1'b1;
        state_n   = S_WAIT;
      end
      S_WAIT: begin
        if (take) state_n = last_reg ? S_OUT : S_IDLE;
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (io.out_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // armed masks the stale done level the adder still shows on the first wait cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      first    <= 1'b1;
      acc      <= FP_ZERO;
      b_reg    <= FP_ZERO;
      last_reg <= 1'b0;
      cnt      <= '0;
      armed    <= 1'b0;
    end else begin
      state <= state_n;
      if (xfer) begin
        if (first) begin
          acc   <= io.in_data;
          cnt   <= CNT_W'(1);
          first <= 1'b0;
        end else begin
          b_reg    <= io.in_data;
          last_reg <= io.in_last;
          cnt      <= (&cnt) ? cnt : cnt + CNT_W'(1);
        end
      end
      if (state == S_ISSUE)     armed <= 1'b0;
      else if (state == S_WAIT) armed <= 1'b1;
      if (take) acc <= res;
      if (state == S_OUT && io.out_ready) first <= 1'b1;
    end
  end

  assign io.in_ready  = in_ready;
  assign io.out_valid = out_valid;
  assign io.add_start = add_start;
  assign io.add_a     = acc;
  assign io.add_b     = b_reg;
  assign io.out_data  = out_valid ? acc : FP_ZERO;
  assign io.out_count = out_valid ? cnt : '0;

endmodule
